bank_arb_l2: RTL and testbench

BANK_ARB_L2 -- requirements
Module: bank_arb_l2

---
 rtl/bank_arb_l2.sv | 116 +++++++++++
 tb/tb_bank_arb_l2.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bank_arb_l2.sv
// Purpose: round-robin arbiter sharing one L2 bank among N_MASTER requesters.
// Latency: grant is combinational; response returns RD_LATENCY cycles after acceptance.
// Backpressure: mem_gnt_i=0 stalls the winner; masters hold requests until granted.
module bank_arb_l2 #(
    parameter int N_MASTER   = 2,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_MASTER-1:0]                   data_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0]        data_add_i,
    input  logic [N_MASTER-1:0]                   data_wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0]        data_wdata_i,
    input  logic [N_MASTER*(DATA_WIDTH/8)-1:0]    data_be_i,
    output logic [N_MASTER-1:0]                   data_gnt_o,
    output logic [N_MASTER-1:0]                   data_r_valid_o,
    output logic [DATA_WIDTH-1:0]                 data_r_rdata_o,
    output logic                                  mem_req_o,
    output logic [ADDR_WIDTH-1:0]                 mem_add_o,
    output logic                                  mem_wen_o,
    output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
    output logic [(DATA_WIDTH/8)-1:0]             mem_be_o,
    input  logic                                  mem_gnt_i,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDW      = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic           any_req;
    logic           accept;

    logic           pipe_vld [RD_LATENCY];
    logic [IDW-1:0] pipe_id  [RD_LATENCY];
    logic           resp_vld;

    // Pick the first requester at or above rr_ptr, wrapping past the top index.
    always_comb begin
        logic found;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            int idx;
            idx = int'(rr_ptr) + i;
            if (idx >= N_MASTER) idx = idx - N_MASTER;
            if (!found && data_req_i[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // Reset masks the request so nothing is granted or accepted while held in reset.
    assign any_req   = (|data_req_i) && !rst;
    assign mem_req_o = any_req;
    assign accept    = any_req && mem_gnt_i;

    // Route the winner's fields to the bank and return the bank's grant to the winner only.
    always_comb begin
        mem_add_o   = '0;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        data_gnt_o  = '0;
        if (any_req) begin
            mem_add_o       = data_add_i[win*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wen_o       = data_wen_i[win];
            mem_wdata_o     = data_wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
            mem_be_o        = data_be_i[win*BE_WIDTH +: BE_WIDTH];
            data_gnt_o[win] = mem_gnt_i;
        end
    end

    // Pointer moves just past the accepted master; a stalled or idle cycle leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (win == IDW'(N_MASTER - 1)) ? '0 : win + IDW'(1);
        end
    end

    // Fixed-latency response tracker: every stage shifts every cycle, so order is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_id[k]  <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_id[0]  <= win;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_id[k]  <= pipe_id[k-1];
            end
        end
    end

    assign resp_vld = pipe_vld[RD_LATENCY-1] && !rst;

    // Steer the due response to its owner; read data is broadcast only while a response is due.
    always_comb begin
        data_r_valid_o = '0;
        data_r_rdata_o = '0;
        if (resp_vld) begin
            data_r_valid_o[pipe_id[RD_LATENCY-1]] = 1'b1;
            data_r_rdata_o                        = mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_bank_arb_l2.sv
// Purpose: directed checks of bank_arb_l2 at RD_LATENCY 1, 2 and 3 sharing one stimulus set.
// Latency: inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
// Backpressure: mem_gnt_i is driven low for stall sequences.
module tb_bank_arb_l2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [23:0] add;
    logic [1:0]  wen;
    logic [127:0] wdata;
    logic [15:0] be;
    logic        mgnt;
    logic [63:0] mrdata;

    logic [1:0]  gnt1, rv1, gnt2, rv2, gnt3, rv3;
    logic [63:0] rd1, rd2, rd3, mwd1, mwd2, mwd3;
    logic        mreq1, mreq2, mreq3, mwen1, mwen2, mwen3;
    logic [11:0] madd1, madd2, madd3;
    logic [7:0]  mbe1, mbe2, mbe3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bank_arb_l2 #(.N_MASTER(2), .DATA_WIDTH(64), .ADDR_WIDTH(12), .RD_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_gnt_o(gnt1), .data_r_valid_o(rv1),
        .data_r_rdata_o(rd1), .mem_req_o(mreq1), .mem_add_o(madd1), .mem_wen_o(mwen1),
        .mem_wdata_o(mwd1), .mem_be_o(mbe1), .mem_gnt_i(mgnt), .mem_rdata_i(mrdata));

    bank_arb_l2 #(.N_MASTER(2), .DATA_WIDTH(64), .ADDR_WIDTH(12), .RD_LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_gnt_o(gnt2), .data_r_valid_o(rv2),
        .data_r_rdata_o(rd2), .mem_req_o(mreq2), .mem_add_o(madd2), .mem_wen_o(mwen2),
        .mem_wdata_o(mwd2), .mem_be_o(mbe2), .mem_gnt_i(mgnt), .mem_rdata_i(mrdata));

    bank_arb_l2 #(.N_MASTER(2), .DATA_WIDTH(64), .ADDR_WIDTH(12), .RD_LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_gnt_o(gnt3), .data_r_valid_o(rv3),
        .data_r_rdata_o(rd3), .mem_req_o(mreq3), .mem_add_o(madd3), .mem_wen_o(mwen3),
        .mem_wdata_o(mwd3), .mem_be_o(mbe3), .mem_gnt_i(mgnt), .mem_rdata_i(mrdata));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of the current cycle, where outputs are checked.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 2'b00; mgnt = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 2'b11;
        add    = {12'h222, 12'h111};
        wen    = 2'b01;              // master 0 reads, master 1 writes
        wdata  = {64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
        be     = {8'hF0, 8'h0F};
        mgnt   = 1'b1;
        mrdata = 64'h0;

        // Reset holds all outputs low even with both masters requesting.
        #1; mid();
        chk("rst_gnt",   64'(gnt1),  64'h0);
        chk("rst_mreq",  64'(mreq1), 64'h0);
        chk("rst_rv",    64'(rv1),   64'h0);
        chk("rst_rdata", rd1,        64'h0);
        tick(); tick();

        // Fairness: alternating grants, responses one cycle later with live read data.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mrdata = 64'hD000 + 64'(i);
            mid();
            chk("fair_gnt", 64'(gnt1), (i % 2 == 0) ? 64'h1 : 64'h2);
            chk("fair_rv",  64'(rv1),  (i == 0) ? 64'h0 : ((i % 2 == 1) ? 64'h1 : 64'h2));
            if (i > 0) chk("fair_rdata", rd1, 64'hD000 + 64'(i));
            if (i == 0) begin
                chk("fair_add0",  64'(madd1), 64'h111);
                chk("fair_wen0",  64'(mwen1), 64'h1);
                chk("fair_be0",   64'(mbe1),  64'h0F);
            end
            if (i == 1) begin
                chk("fair_add1",  64'(madd1), 64'h222);
                chk("fair_wen1",  64'(mwen1), 64'h0);
                chk("fair_wd1",   mwd1,       64'hBBBB_0000_BBBB_0001);
            end
            tick();
        end
        req = 2'b00; mrdata = 64'hD004;
        mid();
        chk("idle_gnt",  64'(gnt1),  64'h0);
        chk("idle_mreq", 64'(mreq1), 64'h0);
        chk("idle_add",  64'(madd1), 64'h0);
        chk("last_rv",   64'(rv1),   64'h2);
        chk("last_rd",   rd1,        64'hD004);
        tick();
        mid();
        chk("norsp_rv", 64'(rv1), 64'h0);
        chk("norsp_rd", rd1,      64'h0);

        // Bank stall: no grants and no responses while mem_gnt_i is low; pointer unchanged.
        tick();
        req = 2'b11; mgnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("stall_gnt",  64'(gnt1),  64'h0);
            chk("stall_mreq", 64'(mreq1), 64'h1);
            chk("stall_rv",   64'(rv1),   64'h0);
            tick();
        end
        mgnt = 1'b1;
        mid();
        chk("stall_release_gnt", 64'(gnt1), 64'h1);
        tick();
        req = 2'b00;
        mid();
        chk("stall_release_rv", 64'(rv1), 64'h1);

        // Single requester: master 1 alone is granted with pointer at 1, then again at 0.
        tick();
        req = 2'b10;
        mid();
        chk("single_gnt_a", 64'(gnt1), 64'h2);
        tick();
        mid();
        chk("single_gnt_b", 64'(gnt1), 64'h2);
        chk("single_rv_a",  64'(rv1),  64'h2);
        tick();
        req = 2'b11;
        mid();
        chk("wrap_gnt", 64'(gnt1), 64'h1);
        chk("wrap_rv",  64'(rv1),  64'h2);
        tick();
        req = 2'b01;
        mid();
        chk("single_gnt_c", 64'(gnt1), 64'h1);
        chk("wrap_rv_b",    64'(rv1),  64'h1);

        // Latency 3: master 1 then master 0 accepted back to back.
        tick();
        do_reset();
        req = 2'b10; mrdata = 64'hE000;
        mid();
        chk("l3_gnt_t", 64'(gnt3), 64'h2);
        tick();
        req = 2'b01;
        mid();
        chk("l3_gnt_t1", 64'(gnt3), 64'h1);
        chk("l3_rv_t1",  64'(rv3),  64'h0);
        tick();
        req = 2'b00;
        mid();
        chk("l3_rv_t2", 64'(rv3), 64'h0);
        tick();
        mrdata = 64'hE003;
        mid();
        chk("l3_rv_t3", 64'(rv3), 64'h2);
        chk("l3_rd_t3", rd3,      64'hE003);
        tick();
        mrdata = 64'hE004;
        mid();
        chk("l3_rv_t4", 64'(rv3), 64'h1);
        chk("l3_rd_t4", rd3,      64'hE004);
        tick();
        mid();
        chk("l3_rv_t5", 64'(rv3), 64'h0);

        // Latency 2 baseline: acceptance at t returns at t+2.
        tick();
        do_reset();
        req = 2'b01;
        mid();
        chk("l2_gnt", 64'(gnt2), 64'h1);
        tick();
        req = 2'b00;
        mid();
        chk("l2_rv_t1", 64'(rv2), 64'h0);
        tick();
        mid();
        chk("l2_rv_t2", 64'(rv2), 64'h1);

        // Latency 2 with reset mid-flight: the in-flight response is discarded.
        tick();
        req = 2'b01;
        mid();
        chk("l2f_gnt", 64'(gnt2), 64'h1);
        tick();
        rst = 1'b1; req = 2'b00;
        mid();
        chk("l2f_rv_rst", 64'(rv2), 64'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("l2f_rv_after", 64'(rv2), 64'h0);
            tick();
        end

        // After reset release the pointer starts at 0.
        req = 2'b11;
        mid();
        chk("post_rst_gnt", 64'(gnt2), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
